// File: rtl/bg3_index_fetch.sv
// Background index fetch: scrolled pixel coordinate -> packed sprite-ROM address,
// then nibble select into a pixel-aligned 4-bit palette index with delayed sync/blank.
module bg3_index_fetch #(
    parameter int          BG_W     = 1024,
    parameter int          BG_H     = 480,
    parameter int          ADDR_W   = 18,
    parameter logic [3:0]  FILL_IDX = 4'h2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              hs,
    input  logic              vs,
    input  logic [9:0]        scroll_x,
    input  logic              scroll_we,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        index,
    output logic              index_valid,
    output logic              hs_out,
    output logic              vs_out,
    output logic              blank_out
);

    localparam logic [10:0] BG_W_11 = 11'(BG_W);
    localparam logic [10:0] BG_H_11 = 11'(BG_H);

    // Both operands are below BG_W, so one conditional subtract keeps xs in range.
    function automatic logic [10:0] wrap_x(input logic [9:0] x, input logic [9:0] s);
        logic [10:0] sum;
        sum = {1'b0, x} + {1'b0, s};
        if (sum >= BG_W_11) begin
            sum = sum - BG_W_11;
        end
        return sum;
    endfunction

    logic [9:0]        pend_q, pend_d;
    logic              pend_flag_q, pend_flag_d;
    logic [9:0]        active_q, active_d;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              xs0_p1_q, xs0_p1_d;
    logic              vld_p1_q, vld_p1_d;
    logic              hs_p1_q, hs_p1_d;
    logic              vs_p1_q, vs_p1_d;
    logic              blank_p1_q, blank_p1_d;

    logic              xs0_p2_q, xs0_p2_d;
    logic              vld_p2_q, vld_p2_d;
    logic              hs_p2_q, hs_p2_d;
    logic              vs_p2_q, vs_p2_d;
    logic              blank_p2_q, blank_p2_d;

    logic [3:0]        index_q, index_d;
    logic              index_valid_q, index_valid_d;
    logic              hs_out_q, hs_out_d;
    logic              vs_out_q, vs_out_d;
    logic              blank_out_q, blank_out_d;

    logic [10:0]       xs;
    logic              in_range;
    logic [20:0]       lin_addr;
    logic              vs_fall;
    logic              scroll_ok;

    always_comb begin
        // Scroll double-buffer: apply uses the old pending value before any same-cycle capture.
        vs_fall     = vs_p1_q & ~vs;
        scroll_ok   = scroll_we && ({1'b0, scroll_x} < BG_W_11);
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        active_d    = active_q;
        if (vs_fall && pend_flag_q) begin
            active_d    = pend_q;
            pend_flag_d = 1'b0;
        end
        if (scroll_ok) begin
            pend_d      = scroll_x;
            pend_flag_d = 1'b1;
        end

        // S1: address generation
        xs         = wrap_x(DrawX, active_q);
        in_range   = blank && ({1'b0, DrawY} < BG_H_11);
        lin_addr   = 21'(DrawY) * 21'(BG_W) + 21'(xs);
        rom_addr_d = in_range ? ADDR_W'(lin_addr >> 1) : rom_addr_q;
        xs0_p1_d   = xs[0];
        vld_p1_d   = in_range;
        hs_p1_d    = hs;
        vs_p1_d    = vs;
        blank_p1_d = blank;

        // S2: ROM access in flight
        xs0_p2_d   = xs0_p1_q;
        vld_p2_d   = vld_p1_q;
        hs_p2_d    = hs_p1_q;
        vs_p2_d    = vs_p1_q;
        blank_p2_d = blank_p1_q;

        // S3: nibble select
        index_d       = vld_p2_q ? (xs0_p2_q ? rom_data[7:4] : rom_data[3:0]) : FILL_IDX;
        index_valid_d = vld_p2_q;
        hs_out_d      = hs_p2_q;
        vs_out_d      = vs_p2_q;
        blank_out_d   = blank_p2_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q        <= '0;
            pend_flag_q   <= 1'b0;
            active_q      <= '0;
            rom_addr_q    <= '0;
            xs0_p1_q      <= 1'b0;
            vld_p1_q      <= 1'b0;
            hs_p1_q       <= 1'b1;
            vs_p1_q       <= 1'b1;
            blank_p1_q    <= 1'b0;
            xs0_p2_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            hs_p2_q       <= 1'b1;
            vs_p2_q       <= 1'b1;
            blank_p2_q    <= 1'b0;
            index_q       <= FILL_IDX;
            index_valid_q <= 1'b0;
            hs_out_q      <= 1'b1;
            vs_out_q      <= 1'b1;
            blank_out_q   <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            pend_flag_q   <= pend_flag_d;
            active_q      <= active_d;
            rom_addr_q    <= rom_addr_d;
            xs0_p1_q      <= xs0_p1_d;
            vld_p1_q      <= vld_p1_d;
            hs_p1_q       <= hs_p1_d;
            vs_p1_q       <= vs_p1_d;
            blank_p1_q    <= blank_p1_d;
            xs0_p2_q      <= xs0_p2_d;
            vld_p2_q      <= vld_p2_d;
            hs_p2_q       <= hs_p2_d;
            vs_p2_q       <= vs_p2_d;
            blank_p2_q    <= blank_p2_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            hs_out_q      <= hs_out_d;
            vs_out_q      <= vs_out_d;
            blank_out_q   <= blank_out_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign hs_out      = hs_out_q;
    assign vs_out      = vs_out_q;
    assign blank_out   = blank_out_q;

endmodule

// File: tb/tb_bg3_index_fetch.sv
// Bench for bg3_index_fetch: directed vector table, hand sequences, and random traffic
// against a queue-based reference model; a second narrow instance covers rejected scroll writes.
module tb_bg3_index_fetch;

    localparam int         BG_W   = 1024;
    localparam int         BG_H   = 480;
    localparam int         ADDR_W = 18;
    localparam logic [3:0] FILL   = 4'h2;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic              blank = 1'b0;
    logic              hs = 1'b1;
    logic              vs = 1'b1;
    logic [9:0]        scroll_x = '0;
    logic              scroll_we = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = '0;
    logic [3:0]        index;
    logic              index_valid, hs_out, vs_out, blank_out;

    logic [ADDR_W-1:0] n_rom_addr;
    logic [7:0]        n_rom_data = '0;
    logic [3:0]        n_index;
    logic              n_index_valid, n_hs_out, n_vs_out, n_blank_out;

    bg3_index_fetch #(.BG_W(BG_W), .BG_H(BG_H), .ADDR_W(ADDR_W), .FILL_IDX(FILL)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .hs(hs), .vs(vs), .scroll_x(scroll_x), .scroll_we(scroll_we),
        .rom_addr(rom_addr), .rom_data(rom_data), .index(index),
        .index_valid(index_valid), .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out)
    );

    bg3_index_fetch #(.BG_W(640), .BG_H(BG_H), .ADDR_W(ADDR_W), .FILL_IDX(FILL)) dut_n (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .hs(hs), .vs(vs), .scroll_x(scroll_x), .scroll_we(scroll_we),
        .rom_addr(n_rom_addr), .rom_data(n_rom_data), .index(n_index),
        .index_valid(n_index_valid), .hs_out(n_hs_out), .vs_out(n_vs_out), .blank_out(n_blank_out)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        return 8'(ai * 29) ^ 8'(ai >> 7) ^ 8'h71;
    endfunction

    function automatic logic [3:0] pick(input logic [7:0] b, input int odd);
        return (odd != 0) ? b[7:4] : b[3:0];
    endfunction

    always @(posedge Clk) rom_data   <= rom_byte(rom_addr);
    always @(posedge Clk) n_rom_data <= rom_byte(n_rom_addr);

    typedef struct {
        logic [3:0] idx;
        logic       vld;
        logic       hs;
        logic       vs;
        logic       blank;
    } out_t;

    out_t pipe_q[$];
    int   m_pend, m_active, m_last_addr;
    bit   m_flag, m_prev_vs;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_active = 0; m_flag = 0; m_prev_vs = 1; m_last_addr = 0;
        pipe_q.delete();
    endtask

    // One clock: model consumes the inputs seen at the edge, then outputs are compared 1 unit later.
    task automatic step();
        int   xs, addr;
        bit   inr;
        out_t o, e;
        @(posedge Clk);
        if (Reset_n) begin
            xs   = (int'(DrawX) + m_active) % BG_W;
            inr  = blank && (int'(DrawY) < BG_H);
            addr = (int'(DrawY) * BG_W + xs) / 2;
            if (inr) m_last_addr = addr;
            o.idx   = inr ? pick(rom_byte(ADDR_W'(addr)), xs % 2) : FILL;
            o.vld   = inr;
            o.hs    = hs;
            o.vs    = vs;
            o.blank = blank;
            pipe_q.push_back(o);
            if (m_prev_vs && !vs && m_flag) begin
                m_active = m_pend;
                m_flag   = 0;
            end
            if (scroll_we && int'(scroll_x) < BG_W) begin
                m_pend = int'(scroll_x);
                m_flag = 1;
            end
            m_prev_vs = vs;
        end
        #1;
        if (pipe_q.size() == 3) e = pipe_q.pop_front();
        else begin
            e.idx = FILL; e.vld = 0; e.hs = 1; e.vs = 1; e.blank = 0;
        end
        check("rom_addr", int'(rom_addr), m_last_addr);
        check("index", int'(index), int'(e.idx));
        check("index_valid", int'(index_valid), int'(e.vld));
        check("hs_out", int'(hs_out), int'(e.hs));
        check("vs_out", int'(vs_out), int'(e.vs));
        check("blank_out", int'(blank_out), int'(e.blank));
        check("n_index_valid", int'(n_index_valid), int'(e.vld));
        check("n_hs_out", int'(n_hs_out), int'(e.hs));
        check("n_vs_out", int'(n_vs_out), int'(e.vs));
        check("n_blank_out", int'(n_blank_out), int'(e.blank));
    endtask

    task automatic vs_pulse();
        vs = 1'b0; step();
        vs = 1'b1; step();
    endtask

    task automatic write_scroll(input int v);
        scroll_x = 10'(v); scroll_we = 1'b1; step();
        scroll_we = 1'b0;
    endtask

    typedef struct {
        int scroll;
        int x;
        int y;
        bit blk;
        int exp_addr;
        bit exp_vld;
        bit exp_odd;
    } vec_t;

    vec_t vecs[12];
    int   cur_scroll;
    logic [11:0] hs_pat;

    initial begin
        vecs[0]  = '{0,    0,   0,   1'b1, 0,      1'b1, 1'b0};
        vecs[1]  = '{0,    1,   0,   1'b1, 0,      1'b1, 1'b1};
        vecs[2]  = '{0,    639, 479, 1'b1, 245567, 1'b1, 1'b1};
        vecs[3]  = '{0,    0,   480, 1'b1, 245567, 1'b0, 1'b0};
        vecs[4]  = '{0,    5,   10,  1'b0, 245567, 1'b0, 1'b0};
        vecs[5]  = '{1023, 1,   2,   1'b1, 1024,   1'b1, 1'b0};
        vecs[6]  = '{1023, 0,   0,   1'b1, 511,    1'b1, 1'b1};
        vecs[7]  = '{1000, 30,  0,   1'b1, 3,      1'b1, 1'b0};
        vecs[8]  = '{1000, 31,  0,   1'b1, 3,      1'b1, 1'b1};
        vecs[9]  = '{512,  600, 1,   1'b1, 556,    1'b1, 1'b0};
        vecs[10] = '{512,  700, 524, 1'b1, 556,    1'b0, 1'b0};
        vecs[11] = '{0,    799, 0,   1'b1, 399,    1'b1, 1'b1};

        model_reset();
        step();
        step();
        Reset_n = 1'b1;

        // Directed vectors, each held for the full pipeline latency.
        cur_scroll = 0;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].scroll != cur_scroll) begin
                blank = 1'b0;
                write_scroll(vecs[i].scroll);
                vs_pulse();
                cur_scroll = vecs[i].scroll;
            end
            DrawX = 10'(vecs[i].x);
            DrawY = 10'(vecs[i].y);
            blank = vecs[i].blk;
            repeat (3) step();
            check($sformatf("vec%0d_addr", i), int'(rom_addr), vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), int'(index_valid), int'(vecs[i].exp_vld));
            check($sformatf("vec%0d_index", i), int'(index),
                  vecs[i].exp_vld ? int'(pick(rom_byte(ADDR_W'(vecs[i].exp_addr)), int'(vecs[i].exp_odd)))
                                  : int'(FILL));
        end

        // Mid-frame write must not take effect until the vs falling edge.
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b1;
        write_scroll(100);
        repeat (3) step();
        check("hold_before_vs_addr", int'(rom_addr), 0);
        check("hold_before_vs_index", int'(index), 1);
        vs_pulse();
        repeat (3) step();
        check("applied_after_vs_addr", int'(rom_addr), 50);

        // Narrow instance (width 640): out-of-range write is dropped.
        check("narrow_s100_addr", int'(n_rom_addr), 50);
        write_scroll(700);
        vs_pulse();
        repeat (3) step();
        check("narrow_reject_addr", int'(n_rom_addr), 50);
        write_scroll(639);
        vs_pulse();
        DrawX = 10'd1;
        repeat (3) step();
        check("narrow_wrap_addr", int'(n_rom_addr), 0);
        check("narrow_wrap_index", int'(n_index), 1);
        DrawX = 10'd2;
        repeat (3) step();
        check("narrow_wrap_odd_index", int'(n_index), 7);

        // Write coinciding with vs fall: old pending applies now, new one next frame.
        DrawX = 10'd0;
        write_scroll(200);
        vs = 1'b0; scroll_x = 10'd300; scroll_we = 1'b1; step();
        scroll_we = 1'b0; vs = 1'b1;
        repeat (3) step();
        check("same_cycle_old_applied", int'(rom_addr), 100);
        vs_pulse();
        repeat (3) step();
        check("same_cycle_new_applied", int'(rom_addr), 150);

        // Full hs pulse edge to edge: output lags the input by three presented cycles.
        hs_pat = 12'b111100001111;
        for (int i = 0; i < 12; i++) begin
            hs = hs_pat[i];
            step();
            if (i >= 2) check($sformatf("hs_delay%0d", i), int'(hs_out), int'(hs_pat[i-2]));
        end
        hs = 1'b1;

        // Asynchronous reset mid-line, no clock edge needed.
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_index", int'(index), int'(FILL));
        check("async_rst_valid", int'(index_valid), 0);
        check("async_rst_hs", int'(hs_out), 1);
        check("async_rst_vs", int'(vs_out), 1);
        check("async_rst_blank", int'(blank_out), 0);
        check("async_rst_addr", int'(rom_addr), 0);
        model_reset();
        step();
        Reset_n = 1'b1;
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b1;
        step();
        step();
        check("post_rst_still_fill", int'(index_valid), 0);
        step();
        check("post_rst_first_valid", int'(index_valid), 1);
        check("post_rst_first_index", int'(index), 1);

        // Randomised traffic with periodic vsync and sporadic scroll writes.
        for (int i = 0; i < 3000; i++) begin
            DrawX     = 10'($urandom_range(0, 799));
            DrawY     = 10'($urandom_range(0, 524));
            blank     = ($urandom_range(0, 3) != 0);
            hs        = ($urandom_range(0, 7) != 0);
            vs        = ((i % 200) < 190);
            scroll_we = ($urandom_range(0, 15) == 0);
            scroll_x  = 10'($urandom_range(0, 1023));
            step();
        end
        scroll_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
